// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin write-back of ALU/LSU results with one skid entry per source
// Redirecting ALU entries win arbitration and flush younger work held in or offered to the stage.
module writeback_arbiter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_target,
    input  logic              alu_target_valid,
    output logic              alu_ok,
    input  logic              lsu_valid,
    input  logic [XLEN-1:0]   lsu_result,
    input  logic [REG_AW-1:0] lsu_rd,
    output logic              lsu_ok,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              rd_release_valid,
    output logic [REG_AW-1:0] rd_release,
    output logic [XLEN-1:0]   pc_target,
    output logic              pc_target_valid,
    output logic              flush_o
);

    logic              alu_full_q, alu_full_d;
    logic              alu_wr_q, alu_wr_d;
    logic              alu_redir_q, alu_redir_d;
    logic [XLEN-1:0]   alu_res_q, alu_res_d;
    logic [REG_AW-1:0] alu_rd_q, alu_rd_d;
    logic [XLEN-1:0]   alu_tgt_q, alu_tgt_d;
    logic              lsu_full_q, lsu_full_d;
    logic [XLEN-1:0]   lsu_res_q, lsu_res_d;
    logic [REG_AW-1:0] lsu_rd_q, lsu_rd_d;
    logic              rr_lsu_q, rr_lsu_d;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              rel_valid_q, rel_valid_d;
    logic [REG_AW-1:0] rel_q, rel_d;
    logic [XLEN-1:0]   pc_target_q, pc_target_d;
    logic              pc_target_valid_q, pc_target_valid_d;
    logic              flush_q, flush_d;

    logic grant_alu, grant_lsu, redirect, alu_acc, lsu_acc;

    // A full entry that wins this cycle drains on the same edge, so ok depends only on stored state.
    always_comb begin
        grant_alu = alu_full_q && (!lsu_full_q || alu_redir_q || !rr_lsu_q);
        grant_lsu = lsu_full_q && !grant_alu;
        alu_ok    = !alu_full_q || grant_alu;
        lsu_ok    = !lsu_full_q || grant_lsu;
        redirect  = grant_alu && alu_redir_q;
        alu_acc   = (alu_valid || alu_target_valid) && alu_ok && !flush_q && !redirect;
        lsu_acc   = lsu_valid && lsu_ok && !flush_q && !redirect;
    end

    always_comb begin
        alu_full_d        = alu_full_q;
        alu_wr_d          = alu_wr_q;
        alu_redir_d       = alu_redir_q;
        alu_res_d         = alu_res_q;
        alu_rd_d          = alu_rd_q;
        alu_tgt_d         = alu_tgt_q;
        lsu_full_d        = lsu_full_q;
        lsu_res_d         = lsu_res_q;
        lsu_rd_d          = lsu_rd_q;
        rr_lsu_d          = rr_lsu_q;
        rf_we_d           = 1'b0;
        rf_waddr_d        = rf_waddr_q;
        rf_wdata_d        = rf_wdata_q;
        rel_valid_d       = 1'b0;
        rel_d             = rel_q;
        pc_target_d       = pc_target_q;
        pc_target_valid_d = 1'b0;
        flush_d           = 1'b0;

        if (alu_full_q && lsu_full_q && !alu_redir_q) begin
            rr_lsu_d = !rr_lsu_q;
        end

        if (grant_alu) begin
            alu_full_d = 1'b0;
            if (alu_wr_q) begin
                rel_valid_d = 1'b1;
                rel_d       = alu_rd_q;
                rf_we_d     = (alu_rd_q != '0);
                rf_waddr_d  = alu_rd_q;
                rf_wdata_d  = alu_res_q;
            end
            if (alu_redir_q) begin
                pc_target_d       = alu_tgt_q;
                pc_target_valid_d = 1'b1;
                flush_d           = 1'b1;
                lsu_full_d        = 1'b0;
            end
        end else if (grant_lsu) begin
            lsu_full_d  = 1'b0;
            rel_valid_d = 1'b1;
            rel_d       = lsu_rd_q;
            rf_we_d     = (lsu_rd_q != '0);
            rf_waddr_d  = lsu_rd_q;
            rf_wdata_d  = lsu_res_q;
        end

        if (alu_acc) begin
            alu_full_d  = 1'b1;
            alu_wr_d    = alu_valid;
            alu_redir_d = alu_target_valid;
            alu_res_d   = alu_result;
            alu_rd_d    = alu_rd;
            alu_tgt_d   = alu_target;
        end
        if (lsu_acc) begin
            lsu_full_d = 1'b1;
            lsu_res_d  = lsu_result;
            lsu_rd_d   = lsu_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_full_q        <= 1'b0;
            alu_wr_q          <= 1'b0;
            alu_redir_q       <= 1'b0;
            alu_res_q         <= '0;
            alu_rd_q          <= '0;
            alu_tgt_q         <= '0;
            lsu_full_q        <= 1'b0;
            lsu_res_q         <= '0;
            lsu_rd_q          <= '0;
            rr_lsu_q          <= 1'b0;
            rf_we_q           <= 1'b0;
            rf_waddr_q        <= '0;
            rf_wdata_q        <= '0;
            rel_valid_q       <= 1'b0;
            rel_q             <= '0;
            pc_target_q       <= '0;
            pc_target_valid_q <= 1'b0;
            flush_q           <= 1'b0;
        end else begin
            alu_full_q        <= alu_full_d;
            alu_wr_q          <= alu_wr_d;
            alu_redir_q       <= alu_redir_d;
            alu_res_q         <= alu_res_d;
            alu_rd_q          <= alu_rd_d;
            alu_tgt_q         <= alu_tgt_d;
            lsu_full_q        <= lsu_full_d;
            lsu_res_q         <= lsu_res_d;
            lsu_rd_q          <= lsu_rd_d;
            rr_lsu_q          <= rr_lsu_d;
            rf_we_q           <= rf_we_d;
            rf_waddr_q        <= rf_waddr_d;
            rf_wdata_q        <= rf_wdata_d;
            rel_valid_q       <= rel_valid_d;
            rel_q             <= rel_d;
            pc_target_q       <= pc_target_d;
            pc_target_valid_q <= pc_target_valid_d;
            flush_q           <= flush_d;
        end
    end

    assign rf_we            = rf_we_q;
    assign rf_waddr         = rf_waddr_q;
    assign rf_wdata         = rf_wdata_q;
    assign rd_release_valid = rel_valid_q;
    assign rd_release       = rel_q;
    assign pc_target        = pc_target_q;
    assign pc_target_valid  = pc_target_valid_q;
    assign flush_o          = flush_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized checks of writeback_arbiter against a queue model
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_target_valid, lsu_valid;
    logic [31:0] alu_result, alu_target, lsu_result;
    logic [4:0]  alu_rd, lsu_rd;
    logic        alu_ok, lsu_ok, rf_we, rd_release_valid, pc_target_valid, flush_o;
    logic [4:0]  rf_waddr, rd_release;
    logic [31:0] rf_wdata, pc_target;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_result(alu_result), .alu_rd(alu_rd),
        .alu_target(alu_target), .alu_target_valid(alu_target_valid), .alu_ok(alu_ok),
        .lsu_valid(lsu_valid), .lsu_result(lsu_result), .lsu_rd(lsu_rd), .lsu_ok(lsu_ok),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_release_valid(rd_release_valid), .rd_release(rd_release),
        .pc_target(pc_target), .pc_target_valid(pc_target_valid), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        redir;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] tgt;
    } beat_t;

    task automatic idle_inputs();
        alu_valid = 0; alu_target_valid = 0; lsu_valid = 0;
        alu_result = 0; alu_target = 0; lsu_result = 0; alu_rd = 0; lsu_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #2;
        n_tests++;
        if ({rf_we, rd_release_valid, pc_target_valid, flush_o} !== 4'b0 ||
            rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rd_release !== 5'd0 || pc_target !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b rel=%b pcv=%b fl=%b waddr=%0d wdata=%h rd=%0d pc=%h, all required 0",
                     rf_we, rd_release_valid, pc_target_valid, flush_o, rf_waddr, rf_wdata, rd_release, pc_target);
        end
        n_tests++;
        if (alu_ok !== 1'b1 || lsu_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_oks: alu_ok=%b lsu_ok=%b required 1 1", alu_ok, lsu_ok);
        end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1; alu_rd = 5; alu_result = 32'h1234;
        tick();
        idle_inputs();
        n_tests++;
        if (alu_ok !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: alu_ok=%b rf_we=%b required 1 0", alu_ok, rf_we);
        end
        tick();
        n_tests++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234 ||
            rd_release_valid !== 1'b1 || rd_release !== 5'd5 || alu_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: we=%b waddr=%0d wdata=%h rel=%b rd=%0d ok=%b required 1 5 1234 1 5 1",
                     rf_we, rf_waddr, rf_wdata, rd_release_valid, rd_release, alu_ok);
        end
        tick();
        n_tests++;
        if (rf_we !== 1'b0 || rd_release_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_strobe_once: we=%b rel=%b required 0 0", rf_we, rd_release_valid);
        end
    endtask

    task automatic test_contention();
        logic [4:0] first, second;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            first  = (rep == 0) ? 5'd3 : 5'd7;
            second = (rep == 0) ? 5'd7 : 5'd3;
            alu_valid = 1; alu_rd = 3; alu_result = 32'hA0 + rep;
            lsu_valid = 1; lsu_rd = 7; lsu_result = 32'hB0 + rep;
            tick();
            idle_inputs();
            n_tests++;
            if (alu_ok !== (rep == 0) || lsu_ok !== (rep == 1)) begin
                n_fail++;
                $display("FAIL contend_oks%0d: alu_ok=%b lsu_ok=%b required %b %b",
                         rep, alu_ok, lsu_ok, rep == 0, rep == 1);
            end
            tick();
            n_tests++;
            if (rf_we !== 1'b1 || rf_waddr !== first || rd_release !== first) begin
                n_fail++;
                $display("FAIL contend_first%0d: we=%b waddr=%0d rel=%0d required 1 %0d", rep, rf_we, rf_waddr, rd_release, first);
            end
            tick();
            n_tests++;
            if (rf_we !== 1'b1 || rf_waddr !== second || rd_release !== second ||
                rf_wdata !== ((second == 5'd7) ? 32'hB0 + rep : 32'hA0 + rep)) begin
                n_fail++;
                $display("FAIL contend_second%0d: we=%b waddr=%0d rel=%0d wdata=%h required 1 %0d",
                         rep, rf_we, rf_waddr, rd_release, rf_wdata, second);
            end
            tick();
        end
    endtask

    task automatic test_x0();
        do_reset();
        alu_valid = 1; alu_rd = 0; alu_result = 32'hFFFF;
        tick();
        idle_inputs();
        tick();
        n_tests++;
        if (rf_we !== 1'b0 || rd_release_valid !== 1'b1 || rd_release !== 5'd0) begin
            n_fail++;
            $display("FAIL x0_write: we=%b rel=%b rd=%0d required 0 1 0", rf_we, rd_release_valid, rd_release);
        end
    endtask

    task automatic test_redirect();
        bit seen9;
        do_reset();
        alu_target_valid = 1; alu_target = 32'h80;
        lsu_valid = 1; lsu_rd = 9; lsu_result = 32'h99;
        tick();
        idle_inputs();
        tick();
        n_tests++;
        if (pc_target_valid !== 1'b1 || pc_target !== 32'h80 || flush_o !== 1'b1 ||
            rf_we !== 1'b0 || rd_release_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_strobe: pcv=%b pc=%h flush=%b we=%b rel=%b required 1 80 1 0 0",
                     pc_target_valid, pc_target, flush_o, rf_we, rd_release_valid);
        end
        n_tests++;
        if (lsu_ok !== 1'b1 || alu_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_oks: alu_ok=%b lsu_ok=%b required 1 1", alu_ok, lsu_ok);
        end
        alu_valid = 1; alu_rd = 11; alu_result = 32'h11;
        lsu_valid = 1; lsu_rd = 10; lsu_result = 32'h10;
        tick();
        idle_inputs();
        n_tests++;
        if (pc_target_valid !== 1'b0 || flush_o !== 1'b0 || pc_target !== 32'h80) begin
            n_fail++;
            $display("FAIL redirect_one_cycle: pcv=%b flush=%b pc=%h required 0 0 80", pc_target_valid, flush_o, pc_target);
        end
        seen9 = 0;
        for (int i = 0; i < 4; i++) begin
            if (rf_we || rd_release_valid) seen9 = 1;
            tick();
        end
        n_tests++;
        if (seen9) begin
            n_fail++;
            $display("FAIL redirect_discard: write or release seen after flush, required none");
        end
    endtask

    task automatic test_back_to_back();
        int bad_ok, bad_we;
        do_reset();
        bad_ok = 0; bad_we = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                alu_valid = 1; alu_rd = 5'(i + 1); alu_result = 32'h100 + i;
            end else begin
                idle_inputs();
            end
            tick();
            if (alu_ok !== 1'b1) bad_ok++;
            if (i >= 1 && i <= 8 && (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'h100 + i - 1)) bad_we++;
        end
        n_tests++;
        if (bad_ok != 0) begin
            n_fail++;
            $display("FAIL b2b_ok: alu_ok low in %0d cycles, required 0", bad_ok);
        end
        n_tests++;
        if (bad_we != 0) begin
            n_fail++;
            $display("FAIL b2b_writes: %0d of 8 write cycles wrong, required 0", bad_we);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1; alu_rd = 12; alu_result = 32'hC;
        lsu_valid = 1; lsu_rd = 13; lsu_result = 32'hD;
        tick();
        idle_inputs();
        tick();
        #1;
        rst = 1;
        #1;
        n_tests++;
        if ({rf_we, rd_release_valid, pc_target_valid, flush_o} !== 4'b0 || alu_ok !== 1'b1 || lsu_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_async: we=%b rel=%b pcv=%b fl=%b aok=%b lok=%b required 0 0 0 0 1 1",
                     rf_we, rd_release_valid, pc_target_valid, flush_o, alu_ok, lsu_ok);
        end
        @(negedge clk);
        rst = 0;
        tick();
        tick();
        n_tests++;
        if (rf_we !== 1'b0 || rd_release_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_nowrite: we=%b rel=%b required 0 0", rf_we, rd_release_valid);
        end
    endtask

    task automatic test_random();
        beat_t aq[$];
        beat_t lq[$];
        beat_t b;
        bit    rr_lsu, flush_prev, redirect, e_aok, e_lok, e_we, e_rel, e_pcv;
        int    win;
        logic [4:0]  e_waddr, e_rd;
        logic [31:0] e_wdata, e_pc;
        do_reset();
        rr_lsu = 0; flush_prev = 0; e_pc = 0; e_waddr = 0; e_wdata = 0; e_rd = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            alu_valid        = ($urandom_range(0, 2) != 0);
            alu_target_valid = ($urandom_range(0, 9) == 0);
            alu_rd           = 5'($urandom_range(0, 31));
            alu_result       = $urandom;
            alu_target       = $urandom;
            lsu_valid        = ($urandom_range(0, 2) != 0);
            lsu_rd           = 5'($urandom_range(0, 31));
            lsu_result       = $urandom;
            #1;
            if (aq.size() > 0 && lq.size() > 0) win = aq[0].redir ? 1 : (rr_lsu ? 2 : 1);
            else if (aq.size() > 0) win = 1;
            else if (lq.size() > 0) win = 2;
            else win = 0;
            e_aok = (aq.size() == 0) || (win == 1);
            e_lok = (lq.size() == 0) || (win == 2);
            n_tests++;
            if (alu_ok !== e_aok || lsu_ok !== e_lok) begin
                n_fail++;
                $display("FAIL rand_ok@%0d: alu_ok=%b lsu_ok=%b required %b %b", cyc, alu_ok, lsu_ok, e_aok, e_lok);
            end
            if (aq.size() > 0 && lq.size() > 0 && !aq[0].redir) rr_lsu = !rr_lsu;
            e_we = 0; e_rel = 0; e_pcv = 0; redirect = 0;
            if (win == 1) begin
                b = aq.pop_front();
                if (b.wr) begin
                    e_rel = 1; e_rd = b.rd; e_we = (b.rd != 0); e_waddr = b.rd; e_wdata = b.res;
                end
                if (b.redir) begin
                    redirect = 1; e_pcv = 1; e_pc = b.tgt;
                    lq.delete();
                end
            end else if (win == 2) begin
                b = lq.pop_front();
                e_rel = 1; e_rd = b.rd; e_we = (b.rd != 0); e_waddr = b.rd; e_wdata = b.res;
            end
            if (!flush_prev && !redirect) begin
                if ((alu_valid || alu_target_valid) && e_aok)
                    aq.push_back('{alu_valid, alu_target_valid, alu_rd, alu_result, alu_target});
                if (lsu_valid && e_lok)
                    lq.push_back('{1'b1, 1'b0, lsu_rd, lsu_result, 32'd0});
            end
            flush_prev = redirect;
            @(posedge clk);
            #1;
            n_tests++;
            if (rf_we !== e_we || rd_release_valid !== e_rel || pc_target_valid !== e_pcv ||
                flush_o !== redirect || pc_target !== e_pc ||
                (e_rel && rd_release !== e_rd) || (e_we && (rf_waddr !== e_waddr || rf_wdata !== e_wdata))) begin
                n_fail++;
                $display("FAIL rand_out@%0d: we=%b rel=%b rd=%0d waddr=%0d wdata=%h pcv=%b pc=%h fl=%b required %b %b %0d %0d %h %b %h %b",
                         cyc, rf_we, rd_release_valid, rd_release, rf_waddr, rf_wdata, pc_target_valid, pc_target, flush_o,
                         e_we, e_rel, e_rd, e_waddr, e_wdata, e_pcv, e_pc, redirect);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_contention();
        test_x0();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
